// File: rtl/buffer_rr_arbiter_pkg.sv
// Shared defaults, FSM state type and width helpers for the buffer round-robin arbiter.
// Widths are derived with clog2 so every user sizes index and counter fields the same way.
package buffer_rr_arbiter_pkg;

  localparam int NUM_CH_DEF    = 4;
  localparam int DATA_W_DEF    = 35;
  localparam int MAX_BURST_DEF = 4;

  // A single channel still needs a one-bit index field.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Counter must hold MAX_BURST itself, not just MAX_BURST-1.
  function automatic int cnt_w(input int max_burst);
    return (max_burst > 0) ? $clog2(max_burst + 1) : 1;
  endfunction

  localparam int CH_IDX_W_DEF    = idx_w(NUM_CH_DEF);
  localparam int BURST_CNT_W_DEF = cnt_w(MAX_BURST_DEF);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

endpackage

// File: rtl/buffer_rr_arbiter_rr_pick.sv
// Rotate-priority selector: first requesting channel after last_grant, wrapping around.
// Purely combinational; no backpressure, pick_vld is 0 when nothing requests.
module rr_pick
  import buffer_rr_arbiter_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int IDX_W  = idx_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  last_grant,
  output logic              pick_vld,
  output logic [IDX_W-1:0]  pick_idx
);

  // Walk offsets from farthest to nearest so the nearest hit is written last and wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      if (req[(int'(last_grant) + i) % NUM_CH]) begin
        pick_vld = 1'b1;
        pick_idx = IDX_W'((int'(last_grant) + i) % NUM_CH);
      end
    end
  end

endmodule

// File: rtl/buffer_rr_arbiter.sv
// Round-robin drain of NUM_CH buffers into one registered slot; 1-cycle arbitration, then 1 word/cycle.
// Stalls with no ack while the slot is full and not taken; a burst ends at MAX_BURST words or an empty channel.
module buffer_rr_arbiter
  import buffer_rr_arbiter_pkg::*;
#(
  parameter int NUM_CH    = NUM_CH_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF,
  localparam int IDX_W    = idx_w(NUM_CH),
  localparam int CNT_W    = cnt_w(MAX_BURST)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        req_empty,
  input  logic [NUM_CH*DATA_W-1:0] req_data,
  output logic [NUM_CH-1:0]        req_ack,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_empty,
  input  logic                     out_take,
  output logic                     writing,
  output logic [IDX_W-1:0]         grant_id,
  output logic                     busy
);

  arb_state_t        state_q;
  arb_state_t        state_d;
  logic [IDX_W-1:0]  grant_d;
  logic [IDX_W-1:0]  last_grant_q;
  logic [IDX_W-1:0]  last_grant_d;
  logic [CNT_W-1:0]  burst_cnt_q;
  logic [CNT_W-1:0]  burst_cnt_d;
  logic [CNT_W-1:0]  burst_cnt_inc;
  logic [DATA_W-1:0] ch_word [NUM_CH];
  logic              slot_free;
  logic              gnt_vld;
  logic              capture;
  logic              burst_done;
  logic              pick_vld;
  logic [IDX_W-1:0]  pick_idx;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      ch_word[c] = req_data[c*DATA_W +: DATA_W];
    end
  end

  // A word leaving this edge frees the slot for a new word on the same edge.
  assign slot_free     = out_empty | out_take;
  assign gnt_vld       = ~req_empty[grant_id];
  assign capture       = (state_q == BURST) & slot_free & gnt_vld;
  assign burst_cnt_inc = burst_cnt_q + CNT_W'(1);
  assign burst_done    = (burst_cnt_inc == CNT_W'(MAX_BURST));
  assign busy          = (state_q != IDLE);

  rr_pick #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_rr_pick (
    .req        (~req_empty),
    .last_grant (last_grant_q),
    .pick_vld   (pick_vld),
    .pick_idx   (pick_idx)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_id;
    last_grant_d = last_grant_q;
    burst_cnt_d  = burst_cnt_q;
    req_ack      = '0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d     = BURST;
          grant_d     = pick_idx;
          burst_cnt_d = '0;
        end
      end
      BURST: begin
        if (capture) begin
          req_ack[grant_id] = 1'b1;
          burst_cnt_d       = burst_cnt_inc;
          if (burst_done) begin
            state_d      = IDLE;
            last_grant_d = grant_id;
          end
        end else if (!gnt_vld) begin
          // Granted channel ran dry: hand priority on even if the slot was blocked.
          state_d      = IDLE;
          last_grant_d = grant_id;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_id     <= '0;
      last_grant_q <= IDX_W'(NUM_CH - 1);
      burst_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_id     <= grant_d;
      last_grant_q <= last_grant_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data  <= '0;
      out_empty <= 1'b1;
      writing   <= 1'b0;
    end else begin
      writing <= capture;
      if (capture) begin
        out_data  <= ch_word[grant_id];
        out_empty <= 1'b0;
      end else if (out_take && !out_empty) begin
        out_data  <= '0;
        out_empty <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_buffer_rr_arbiter.sv
// Randomised bench for buffer_rr_arbiter against a queue-based model of the arbitration rules.
// Each scenario task checks the full output vector every cycle plus its own targeted properties.
module tb_buffer_rr_arbiter;

  localparam int NUM_CH    = 4;
  localparam int DATA_W    = 35;
  localparam int MAX_BURST = 4;
  localparam int VEC_W     = NUM_CH + 1 + DATA_W + 1 + 2 + 1;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_CH-1:0]        req_empty;
  logic [NUM_CH*DATA_W-1:0] req_data;
  logic [NUM_CH-1:0]        req_ack;
  logic [DATA_W-1:0]        out_data;
  logic                     out_empty;
  logic                     out_take;
  logic                     writing;
  logic [1:0]               grant_id;
  logic                     busy;

  buffer_rr_arbiter #(
    .NUM_CH    (NUM_CH),
    .DATA_W    (DATA_W),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_empty (req_empty),
    .req_data  (req_data),
    .req_ack   (req_ack),
    .out_data  (out_data),
    .out_empty (out_empty),
    .out_take  (out_take),
    .writing   (writing),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Channel contents as plain FIFOs of words.
  logic [DATA_W-1:0] chq [NUM_CH][$];
  int                cap_log [$];

  // Model: which channel owns the slot, how many words it has delivered, and what sits in the slot.
  bit                m_busy;
  int                m_gnt;
  int                m_last;
  int                m_cnt;
  bit                m_vld;
  logic [DATA_W-1:0] m_out;
  bit                m_wr;

  int n_vec;
  int n_err;

  function automatic logic [DATA_W-1:0] rand_word();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[DATA_W-1:0];
  endfunction

  task automatic model_reset();
    m_busy = 1'b0;
    m_gnt  = 0;
    m_last = NUM_CH - 1;
    m_cnt  = 0;
    m_vld  = 1'b0;
    m_out  = '0;
    m_wr   = 1'b0;
  endtask

  task automatic drive_inputs(input logic take);
    out_take = take;
    for (int c = 0; c < NUM_CH; c++) begin
      req_empty[c] = (chq[c].size() == 0);
      req_data[c*DATA_W +: DATA_W] = (chq[c].size() > 0) ? chq[c][0] : rand_word();
    end
  endtask

  // One clock: drive at negedge, sample, then advance the model across the rising edge.
  task automatic step(input logic take, output logic [VEC_W-1:0] o, output logic [VEC_W-1:0] e);
    logic [NUM_CH-1:0] e_ack;
    bit                cap;
    bit                found;
    int                g;
    @(negedge clk);
    drive_inputs(take);
    #1;
    cap   = m_busy && (!m_vld || take) && (chq[m_gnt].size() > 0);
    e_ack = '0;
    if (cap) e_ack[m_gnt] = 1'b1;
    e = {e_ack, ~m_vld, m_out, m_wr, 2'(m_gnt), m_busy};
    o = {req_ack, out_empty, out_data, writing, grant_id, busy};
    @(posedge clk);
    m_wr = cap;
    g    = m_gnt;
    if (cap) begin
      m_out = chq[g].pop_front();
      m_vld = 1'b1;
      m_cnt++;
      cap_log.push_back(g);
      if (m_cnt == MAX_BURST) begin
        m_busy = 1'b0;
        m_last = g;
      end
    end else begin
      if (take && m_vld) begin
        m_vld = 1'b0;
        m_out = '0;
      end
      if (m_busy && chq[g].size() == 0) begin
        m_busy = 1'b0;
        m_last = g;
      end else if (!m_busy) begin
        found = 1'b0;
        for (int k = 1; k <= NUM_CH; k++) begin
          if (!found && chq[(m_last + k) % NUM_CH].size() > 0) begin
            found  = 1'b1;
            m_gnt  = (m_last + k) % NUM_CH;
            m_busy = 1'b1;
            m_cnt  = 0;
          end
        end
      end
    end
  endtask

  task automatic start_test();
    for (int c = 0; c < NUM_CH; c++) chq[c].delete();
    cap_log.delete();
    @(posedge clk);
    #2 reset = 1'b1;
    model_reset();
    drive_inputs(1'b0);
    @(posedge clk);
    #2 reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [VEC_W-1:0] o, e;
    for (int c = 0; c < NUM_CH; c++) begin
      chq[c].delete();
      chq[c].push_back(rand_word());
    end
    cap_log.delete();
    @(posedge clk);
    #2 reset = 1'b1;
    model_reset();
    drive_inputs(1'b1);
    #1;
    e = {4'b0000, 1'b1, {DATA_W{1'b0}}, 1'b0, 2'd0, 1'b0};
    o = {req_ack, out_empty, out_data, writing, grant_id, busy};
    n_vec++;
    if (o !== e) begin
      n_err++;
      $display("FAIL reset_async: got %h want %h", o, e);
    end
    @(posedge clk);
    #1;
    o = {req_ack, out_empty, out_data, writing, grant_id, busy};
    n_vec++;
    if (o !== e) begin
      n_err++;
      $display("FAIL reset_held: got %h want %h", o, e);
    end
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, o, e);
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL reset_release cyc%0d: got %h want %h", i, o, e);
      end
    end
    n_vec++;
    if (cap_log.size() == 0 || cap_log[0] != 0) begin
      n_err++;
      $display("FAIL reset_first_grant: got %0d captures first ch %0d want ch 0", cap_log.size(),
               (cap_log.size() > 0) ? cap_log[0] : -1);
    end
  endtask

  task automatic test_single_ch2();
    logic [VEC_W-1:0]  o, e;
    logic [DATA_W-1:0] w;
    start_test();
    w = rand_word();
    chq[2].push_back(w);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, o, e);
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL single_ch2 cyc%0d: got %h want %h", i, o, e);
      end
      if (i == 1) begin
        n_vec++;
        if (o[VEC_W-1 -: NUM_CH] !== 4'b0100 || o[2:1] !== 2'd2) begin
          n_err++;
          $display("FAIL single_ch2_ack: got ack %b grant %0d want ack 0100 grant 2", o[VEC_W-1 -: NUM_CH], o[2:1]);
        end
      end
      if (i == 2) begin
        n_vec++;
        if (o[3] !== 1'b1 || o[38:4] !== w) begin
          n_err++;
          $display("FAIL single_ch2_word: got writing %b data %h want writing 1 data %h", o[3], o[38:4], w);
        end
      end
      if (i == 3) begin
        n_vec++;
        if (o[3] !== 1'b0 || o[39] !== 1'b1) begin
          n_err++;
          $display("FAIL single_ch2_drain: got writing %b empty %b want 0 1", o[3], o[39]);
        end
      end
    end
  endtask

  task automatic test_rr_order();
    logic [VEC_W-1:0] o, e;
    start_test();
    for (int i = 0; i < 28; i++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        while (chq[c].size() < 2) chq[c].push_back(rand_word());
      end
      step(1'b1, o, e);
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL rr_order cyc%0d: got %h want %h", i, o, e);
      end
    end
    n_vec++;
    if (cap_log.size() < 20) begin
      n_err++;
      $display("FAIL rr_order_count: got %0d captures want at least 20", cap_log.size());
    end else begin
      for (int k = 0; k < 20; k++) begin
        n_vec++;
        if (cap_log[k] != (k / MAX_BURST) % NUM_CH) begin
          n_err++;
          $display("FAIL rr_order_seq[%0d]: got ch %0d want ch %0d", k, cap_log[k], (k / MAX_BURST) % NUM_CH);
        end
      end
    end
  endtask

  task automatic test_zero_word();
    logic [VEC_W-1:0] o, e;
    start_test();
    chq[1].push_back('0);
    chq[1].push_back(rand_word());
    for (int i = 0; i < 6; i++) begin
      step(1'b1, o, e);
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL zero_word cyc%0d: got %h want %h", i, o, e);
      end
      if (i == 2) begin
        n_vec++;
        if (o[39] !== 1'b0 || o[38:4] !== '0 || o[3] !== 1'b1) begin
          n_err++;
          $display("FAIL zero_word_valid: got empty %b data %h writing %b want 0 0 1", o[39], o[38:4], o[3]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [VEC_W-1:0] o, e;
    int takes [12] = '{1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
    start_test();
    for (int k = 0; k < 4; k++) chq[0].push_back(rand_word());
    chq[2].push_back(rand_word());
    for (int i = 0; i < 12; i++) begin
      step(takes[i] != 0, o, e);
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL backpressure cyc%0d: got %h want %h", i, o, e);
      end
      if (i >= 2 && i <= 5) begin
        n_vec++;
        if (o[VEC_W-1 -: NUM_CH] !== '0 || o[39] !== 1'b0) begin
          n_err++;
          $display("FAIL backpressure_hold cyc%0d: got ack %b empty %b want 0000 0", i, o[VEC_W-1 -: NUM_CH], o[39]);
        end
      end
      if (i == 7) begin
        n_vec++;
        if (o[39] !== 1'b0 || o[3] !== 1'b1) begin
          n_err++;
          $display("FAIL backpressure_nobubble: got empty %b writing %b want 0 1", o[39], o[3]);
        end
      end
    end
  endtask

  task automatic test_early_empty();
    logic [VEC_W-1:0] o, e;
    int exp_seq [4] = '{1, 1, 2, 2};
    start_test();
    for (int k = 0; k < 2; k++) begin
      chq[1].push_back(rand_word());
      chq[2].push_back(rand_word());
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b1, o, e);
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL early_empty cyc%0d: got %h want %h", i, o, e);
      end
    end
    n_vec++;
    if (cap_log.size() != 4) begin
      n_err++;
      $display("FAIL early_empty_count: got %0d captures want 4", cap_log.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_vec++;
        if (cap_log[k] != exp_seq[k]) begin
          n_err++;
          $display("FAIL early_empty_seq[%0d]: got ch %0d want ch %0d", k, cap_log[k], exp_seq[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [VEC_W-1:0] o, e;
    start_test();
    for (int k = 0; k < 4; k++) chq[0].push_back(rand_word());
    for (int k = 0; k < 2; k++) chq[1].push_back(rand_word());
    for (int i = 0; i < 3; i++) begin
      step(1'b0, o, e);
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL mid_reset_pre cyc%0d: got %h want %h", i, o, e);
      end
    end
    #2 reset = 1'b1;
    #1;
    e = {4'b0000, 1'b1, {DATA_W{1'b0}}, 1'b0, 2'd0, 1'b0};
    o = {req_ack, out_empty, out_data, writing, grant_id, busy};
    n_vec++;
    if (o !== e) begin
      n_err++;
      $display("FAIL mid_reset_drop: got %h want %h", o, e);
    end
    model_reset();
    @(posedge clk);
    #2 reset = 1'b0;
    cap_log.delete();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, o, e);
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL mid_reset_post cyc%0d: got %h want %h", i, o, e);
      end
    end
    n_vec++;
    if (cap_log.size() == 0 || cap_log[0] != 0) begin
      n_err++;
      $display("FAIL mid_reset_winner: got %0d captures first ch %0d want ch 0", cap_log.size(),
               (cap_log.size() > 0) ? cap_log[0] : -1);
    end
  endtask

  task automatic test_random();
    logic [VEC_W-1:0] o, e;
    start_test();
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(0, 3) == 0 && chq[c].size() < 3) chq[c].push_back(rand_word());
      end
      step($urandom_range(0, 3) != 0, o, e);
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL random cyc%0d: got %h want %h", i, o, e);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "simulation time limit");
  end

  initial begin
    reset     = 1'b0;
    out_take  = 1'b0;
    req_empty = '1;
    req_data  = '0;
    n_vec     = 0;
    n_err     = 0;
    model_reset();
    test_reset();
    test_single_ch2();
    test_rr_order();
    test_zero_word();
    test_backpressure();
    test_early_empty();
    test_reset_mid_burst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
